// File: rtl/axi4_pkg.sv
// Shared AXI4 constants, FSM states and request legality check.
// AXI_SLV_WRAP_EN: when defined, WRAP bursts of 2/4/8/16 beats are legal.
package axi4_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [2:0] SIZE_4B = 3'b010;

`ifdef AXI_SLV_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
    typedef enum logic {R_IDLE, R_DATA} rstate_e;

    // A request is flagged once at the address phase; the burst still runs
    // its full beat count so the master sees a well-formed response.
    function automatic logic req_err(
        input logic [2:0] size,
        input logic [1:0] burst,
        input logic [7:0] len,
        input logic [1:0] alo
    );
        logic err;
        logic wrap_ok;
        wrap_ok = (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)
                  && (alo == 2'b00);
        err = (size != SIZE_4B) || (burst == 2'b11);
        if (burst == BURST_WRAP && !(WRAP_EN && wrap_ok)) err = 1'b1;
        return err;
    endfunction

endpackage

// File: rtl/axi4_burst_addr.sv
// Next-beat address generator and RAM range check for one AXI channel.
// Purely combinational; instantiated once per direction.
module axi4_burst_addr
    import axi4_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_WORDS  = 1024,
    parameter int IDX_W      = 10,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [7:0]            len_i,
    input  logic [1:0]            burst_i,
    output logic [ADDR_WIDTH-1:0] next_o,
    output logic                  in_range_o,
    output logic [IDX_W-1:0]      idx_o
);

    localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(MEM_WORDS) << 2;

    logic [ADDR_WIDTH-1:0] off;
    logic [ADDR_WIDTH-1:0] incr;
    logic [ADDR_WIDTH-1:0] mask;

    assign off  = addr_i - BASE_ADDR;
    assign incr = addr_i + ADDR_WIDTH'(4);
    // Wrap window is (len+1)*4 bytes, i.e. mask = len*4 + 3.
    assign mask = ADDR_WIDTH'({len_i, 2'b11});

    assign in_range_o = (addr_i >= BASE_ADDR) && ({1'b0, off} < LIMIT);
    assign idx_o      = off[IDX_W+1:2];

    always_comb begin
        next_o = incr;
        unique case (burst_i)
            BURST_FIXED: next_o = addr_i;
            BURST_WRAP:  next_o = (addr_i & ~mask) | (incr & mask);
            default:     next_o = incr;
        endcase
    end

endmodule

// File: rtl/axi4_slave_ram.sv
// AXI4 responder over a word RAM; independent write and read FSMs.
// AXI_SLV_WRAP_EN (see axi4_pkg) enables WRAP bursts.
module axi4_slave_ram
    import axi4_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_WORDS  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [ID_WIDTH-1:0]     s_axi_awid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]              s_axi_awlen,
    input  logic [2:0]              s_axi_awsize,
    input  logic [1:0]              s_axi_awburst,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ID_WIDTH-1:0]     s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]              s_axi_arlen,
    input  logic [2:0]              s_axi_arsize,
    input  logic [1:0]              s_axi_arburst,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [ID_WIDTH-1:0]     s_axi_rid,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

    wstate_e               ws_q, ws_d;
    logic [ID_WIDTH-1:0]   wid_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [7:0]            wlen_q, wcnt_q;
    logic [1:0]            wburst_q;
    logic                  werr_q;
    logic                  aw_hs, w_hs, w_final, w_we, w_inr;
    logic [ADDR_WIDTH-1:0] w_nxt;
    logic [IDX_W-1:0]      w_idx;

    rstate_e               rs_q, rs_d;
    logic [ID_WIDTH-1:0]   rid_q;
    logic [ADDR_WIDTH-1:0] raddr_q;
    logic [7:0]            rlen_q, rcnt_q;
    logic [1:0]            rburst_q;
    logic                  rerr_q, rlast_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;
    logic                  ar_hs, r_hs, ar_err, fetch, f_bad, r_inr;
    logic [ADDR_WIDTH-1:0] r_cur, r_nxt;
    logic [7:0]            r_len;
    logic [1:0]            r_burst;
    logic [IDX_W-1:0]      r_idx;

    // ---------------- write channel ----------------
    assign aw_hs   = s_axi_awvalid && s_axi_awready;
    assign w_hs    = s_axi_wvalid && s_axi_wready;
    assign w_final = (wcnt_q == wlen_q);
    assign w_we    = w_hs && !werr_q && w_inr && !areset;

    axi4_burst_addr #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .MEM_WORDS (MEM_WORDS),
        .IDX_W     (IDX_W),
        .BASE_ADDR (BASE_ADDR)
    ) u_waddr (
        .addr_i    (waddr_q),
        .len_i     (wlen_q),
        .burst_i   (wburst_q),
        .next_o    (w_nxt),
        .in_range_o(w_inr),
        .idx_o     (w_idx)
    );

    always_ff @(posedge aclk) begin
        if (areset) ws_q <= W_IDLE;
        else        ws_q <= ws_d;
    end

    always_comb begin
        ws_d = ws_q;
        unique case (ws_q)
            W_IDLE:  if (aw_hs) ws_d = W_DATA;
            W_DATA:  if (w_hs && w_final) ws_d = W_RESP;
            W_RESP:  if (s_axi_bready) ws_d = W_IDLE;
            default: ws_d = W_IDLE;
        endcase
    end

    always_comb begin
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        s_axi_bid     = '0;
        s_axi_bresp   = RESP_OKAY;
        unique case (ws_q)
            W_IDLE: s_axi_awready = 1'b1;
            W_DATA: s_axi_wready  = 1'b1;
            W_RESP: begin
                s_axi_bvalid = 1'b1;
                s_axi_bid    = wid_q;
                s_axi_bresp  = werr_q ? RESP_SLVERR : RESP_OKAY;
            end
            default: ;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            wid_q    <= '0;
            waddr_q  <= '0;
            wlen_q   <= '0;
            wcnt_q   <= '0;
            wburst_q <= BURST_INCR;
            werr_q   <= 1'b0;
        end else if (aw_hs) begin
            wid_q    <= s_axi_awid;
            waddr_q  <= s_axi_awaddr;
            wlen_q   <= s_axi_awlen;
            wcnt_q   <= '0;
            wburst_q <= s_axi_awburst;
            werr_q   <= req_err(s_axi_awsize, s_axi_awburst,
                                s_axi_awlen, s_axi_awaddr[1:0]);
        end else if (w_hs) begin
            waddr_q <= w_nxt;
            wcnt_q  <= wcnt_q + 8'd1;
            if (!w_inr || (s_axi_wlast != w_final)) werr_q <= 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (w_we) begin
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
                if (s_axi_wstrb[b]) mem_q[w_idx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
            end
        end
    end

    // ---------------- read channel ----------------
    // raddr_q holds the address of the next beat to fetch, so the fetch
    // address is the request itself on AR and raddr_q on each R handshake.
    assign ar_hs   = s_axi_arvalid && s_axi_arready;
    assign r_hs    = s_axi_rvalid && s_axi_rready;
    assign ar_err  = req_err(s_axi_arsize, s_axi_arburst,
                             s_axi_arlen, s_axi_araddr[1:0]);
    assign r_cur   = (rs_q == R_IDLE) ? s_axi_araddr  : raddr_q;
    assign r_len   = (rs_q == R_IDLE) ? s_axi_arlen   : rlen_q;
    assign r_burst = (rs_q == R_IDLE) ? s_axi_arburst : rburst_q;
    assign fetch   = ar_hs || (r_hs && !rlast_q);
    assign f_bad   = (ar_hs ? ar_err : rerr_q) || !r_inr;

    axi4_burst_addr #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .MEM_WORDS (MEM_WORDS),
        .IDX_W     (IDX_W),
        .BASE_ADDR (BASE_ADDR)
    ) u_raddr (
        .addr_i    (r_cur),
        .len_i     (r_len),
        .burst_i   (r_burst),
        .next_o    (r_nxt),
        .in_range_o(r_inr),
        .idx_o     (r_idx)
    );

    always_ff @(posedge aclk) begin
        if (areset) rs_q <= R_IDLE;
        else        rs_q <= rs_d;
    end

    always_comb begin
        rs_d = rs_q;
        unique case (rs_q)
            R_IDLE:  if (ar_hs) rs_d = R_DATA;
            R_DATA:  if (r_hs && rlast_q) rs_d = R_IDLE;
            default: rs_d = R_IDLE;
        endcase
    end

    always_comb begin
        s_axi_arready = (rs_q == R_IDLE);
        s_axi_rvalid  = (rs_q == R_DATA);
        s_axi_rid     = rid_q;
        s_axi_rdata   = rdata_q;
        s_axi_rresp   = rresp_q;
        s_axi_rlast   = rlast_q;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            rid_q    <= '0;
            raddr_q  <= '0;
            rlen_q   <= '0;
            rcnt_q   <= '0;
            rburst_q <= BURST_INCR;
            rerr_q   <= 1'b0;
            rlast_q  <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else begin
            if (ar_hs) begin
                rid_q    <= s_axi_arid;
                rlen_q   <= s_axi_arlen;
                rcnt_q   <= '0;
                rburst_q <= s_axi_arburst;
                rerr_q   <= ar_err;
                rlast_q  <= (s_axi_arlen == 8'd0);
            end else if (r_hs) begin
                if (rlast_q) begin
                    rlast_q <= 1'b0;
                end else begin
                    rcnt_q  <= rcnt_q + 8'd1;
                    rlast_q <= (rcnt_q + 8'd1 == rlen_q);
                end
            end
            if (fetch) begin
                raddr_q <= r_nxt;
                rresp_q <= f_bad ? RESP_SLVERR : RESP_OKAY;
                rdata_q <= f_bad ? '0 : mem_q[r_idx];
            end
        end
    end

endmodule

// File: tb/tb_axi4_slave_ram.sv
// Directed bench for axi4_slave_ram with a transaction-level memory model.
// Build with AXI_SLV_WRAP_EN defined to exercise legal WRAP bursts.
module tb_axi4_slave_ram;

    localparam int MEM_WORDS = 1024;
`ifdef AXI_SLV_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } rbeat_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } bbeat_t;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [3:0]  s_axi_awid = '0;
    logic [31:0] s_axi_awaddr = '0;
    logic [7:0]  s_axi_awlen = '0;
    logic [2:0]  s_axi_awsize = 3'd2;
    logic [1:0]  s_axi_awburst = 2'b01;
    logic        s_axi_awvalid = 1'b0;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_wlast = 1'b0;
    logic        s_axi_wvalid = 1'b0;
    logic        s_axi_wready;
    logic [3:0]  s_axi_bid;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready = 1'b0;
    logic [3:0]  s_axi_arid = '0;
    logic [31:0] s_axi_araddr = '0;
    logic [7:0]  s_axi_arlen = '0;
    logic [2:0]  s_axi_arsize = 3'd2;
    logic [1:0]  s_axi_arburst = 2'b01;
    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic [3:0]  s_axi_rid;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rlast;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem_m [MEM_WORDS];
    logic [31:0] wd  [16];
    logic [3:0]  wsb [16];
    rbeat_t exp_r[$], got_r[$];
    bbeat_t exp_b[$], got_b[$];

    axi4_slave_ram dut (
        .aclk(aclk), .areset(areset),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr),
        .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize),
        .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wlast(s_axi_wlast), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr),
        .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize),
        .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata),
        .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---- behavioural model: AXI rules in plain arithmetic ----
    function automatic logic m_err(input logic [2:0] size, input logic [1:0] burst,
                                   input logic [7:0] len, input logic [31:0] addr);
        if (size != 3'd2 || burst == 2'b11) return 1'b1;
        if (burst == 2'b10) begin
            if (!WRAP_EN) return 1'b1;
            if (!(len == 1 || len == 3 || len == 7 || len == 15)) return 1'b1;
            if (addr % 4 != 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_addr(input logic [31:0] addr, input logic [7:0] len,
                                           input logic [1:0] burst, input int i);
        logic [31:0] a, span, base;
        a = addr;
        span = (32'(len) + 1) * 4;
        for (int k = 0; k < i; k++) begin
            if (burst == 2'b10) begin
                base = a - (a % span);
                a = base + ((a - base + 4) % span);
            end else if (burst != 2'b00) begin
                a = a + 4;
            end
        end
        return a;
    endfunction

    function automatic logic m_inr(input logic [31:0] a);
        return a < 32'(MEM_WORDS * 4);
    endfunction

    function automatic logic [31:0] gr_data(input int i);
        return (i < got_r.size()) ? got_r[i].data : 32'hDEAD_BEEF;
    endfunction
    function automatic logic [1:0] gr_resp(input int i);
        return (i < got_r.size()) ? got_r[i].resp : 2'b11;
    endfunction
    function automatic logic gr_last(input int i);
        return (i < got_r.size()) ? got_r[i].last : 1'bx;
    endfunction
    function automatic bbeat_t gb();
        return (got_b.size() > 0) ? got_b[0] : 6'h3F;
    endfunction

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input int bad_last, input int bdelay);
        logic err, wl;
        logic [31:0] a;
        int n;
        err = m_err(3'd2, burst, len, addr);
        for (int i = 0; i <= int'(len); i++) begin
            a = m_addr(addr, len, burst, i);
            wl = (bad_last >= 0) ? (i == bad_last) : (i == int'(len));
            if (!err && m_inr(a))
                for (int b = 0; b < 4; b++)
                    if (wsb[i][b]) mem_m[a[11:2]][8*b +: 8] = wd[i][8*b +: 8];
            if (!m_inr(a) || wl != (i == int'(len))) err = 1'b1;
        end
        exp_b.push_back('{id, err ? 2'b10 : 2'b00});
        got_b.delete();
        @(posedge aclk); #1;
        s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len;
        s_axi_awsize = 3'd2; s_axi_awburst = burst; s_axi_awvalid = 1'b1;
        for (n = 0; n < 50; n++) begin @(negedge aclk); if (s_axi_awready) break; end
        chk("aw_accept", 32'(n < 50), 1);
        @(posedge aclk); #1 s_axi_awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            s_axi_wdata = wd[i]; s_axi_wstrb = wsb[i]; s_axi_wvalid = 1'b1;
            s_axi_wlast = (bad_last >= 0) ? (i == bad_last) : (i == int'(len));
            for (n = 0; n < 50; n++) begin @(negedge aclk); if (s_axi_wready) break; end
            if (i == 0) chk("aw_to_wready_lat", n, 0);
            else chk("w_accept", 32'(n < 50), 1);
            @(posedge aclk); #1;
        end
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
        for (n = 0; n < 50; n++) begin @(negedge aclk); if (s_axi_bvalid) break; end
        chk("wlast_to_bvalid_lat", n, 0);
        repeat (bdelay) begin @(posedge aclk); @(negedge aclk); end
        chk("bvalid_held", s_axi_bvalid, 1);
        @(posedge aclk); #1 s_axi_bready = 1'b1;
        @(negedge aclk);
        @(posedge aclk); #1 s_axi_bready = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [3:0] pat);
        logic err, bad;
        logic [31:0] a;
        int n, c, nhs;
        err = m_err(3'd2, burst, len, addr);
        for (int i = 0; i <= int'(len); i++) begin
            a = m_addr(addr, len, burst, i);
            bad = err || !m_inr(a);
            exp_r.push_back('{id, bad ? 32'h0 : mem_m[a[11:2]], bad ? 2'b10 : 2'b00,
                              i == int'(len)});
        end
        got_r.delete();
        @(posedge aclk); #1;
        s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
        s_axi_arsize = 3'd2; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
        for (n = 0; n < 50; n++) begin @(negedge aclk); if (s_axi_arready) break; end
        chk("ar_accept", 32'(n < 50), 1);
        @(posedge aclk); #1 s_axi_arvalid = 1'b0;
        c = 0; nhs = 0;
        while (nhs <= int'(len) && c < 200) begin
            s_axi_rready = pat[c % 4];
            @(negedge aclk);
            if (c == 0) chk("ar_to_rvalid_lat", s_axi_rvalid, 1);
            if (s_axi_rvalid && s_axi_rready) nhs++;
            @(posedge aclk); #1;
            c++;
        end
        s_axi_rready = 1'b0;
        chk("r_beat_count", nhs, 32'(len) + 1);
        @(negedge aclk);
        chk("rvalid_drop", s_axi_rvalid, 0);
        chk("arready_back", s_axi_arready, 1);
    endtask

    // ---- compare process: DUT outputs vs model expectations ----
    always @(negedge aclk) begin
        if (!areset) begin
            if (s_axi_rvalid) begin
                if (exp_r.size() == 0) chk("r_unexpected", 1, 0);
                else begin
                    chk("rid", s_axi_rid, exp_r[0].id);
                    chk("rdata", s_axi_rdata, exp_r[0].data);
                    chk("rresp", s_axi_rresp, exp_r[0].resp);
                    chk("rlast", s_axi_rlast, exp_r[0].last);
                    if (s_axi_rready) begin
                        got_r.push_back('{s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast});
                        void'(exp_r.pop_front());
                    end
                end
            end
            if (s_axi_bvalid) begin
                chk("awready_during_b", s_axi_awready, 0);
                if (exp_b.size() == 0) chk("b_unexpected", 1, 0);
                else begin
                    chk("bid", s_axi_bid, exp_b[0].id);
                    chk("bresp", s_axi_bresp, exp_b[0].resp);
                    if (s_axi_bready) begin
                        got_b.push_back('{s_axi_bid, s_axi_bresp});
                        void'(exp_b.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) mem_m[i] = '0;
        repeat (3) @(posedge aclk);
        #1 areset = 1'b0;
        @(negedge aclk);
        chk("rst_awready", s_axi_awready, 1);
        chk("rst_arready", s_axi_arready, 1);
        chk("rst_wready", s_axi_wready, 0);
        chk("rst_bvalid", s_axi_bvalid, 0);
        chk("rst_rvalid", s_axi_rvalid, 0);
        chk("rst_rlast", s_axi_rlast, 0);
        chk("rst_rdata", s_axi_rdata, 0);
        chk("rst_rid_bid_resp", {s_axi_rid, s_axi_bid, s_axi_rresp, s_axi_bresp}, 0);

        // INCR burst write and readback
        for (int i = 0; i < 4; i++) begin wd[i] = 32'h1111_1111 * (i + 1); wsb[i] = 4'hF; end
        do_write(4'd5, 32'h10, 8'd3, 2'b01, -1, 0);
        chk("t1_bresp", gb().resp, 2'b00);
        chk("t1_bid", gb().id, 4'd5);
        do_read(4'd7, 32'h10, 8'd3, 2'b01, 4'hF);
        for (int i = 0; i < 4; i++) begin
            chk("t1_rdata", gr_data(i), 32'h1111_1111 * (i + 1));
            chk("t1_rlast", gr_last(i), i == 3);
            chk("t1_rresp", gr_resp(i), 2'b00);
        end

        // byte strobes
        wd[0] = 32'hFFFF_FFFF; wsb[0] = 4'hF;
        do_write(4'd1, 32'h40, 8'd0, 2'b01, -1, 0);
        wd[0] = 32'hAABB_CCDD; wsb[0] = 4'b0101;
        do_write(4'd2, 32'h40, 8'd0, 2'b01, -1, 0);
        do_read(4'd3, 32'h40, 8'd0, 2'b01, 4'hF);
        chk("t2_strobe", gr_data(0), 32'hFFBB_FFDD);

        // FIXED burst
        wd[0] = 32'hCAFE_F00D; wsb[0] = 4'hF;
        do_write(4'd4, 32'h84, 8'd0, 2'b01, -1, 0);
        for (int i = 0; i < 3; i++) begin wd[i] = 32'(i + 1); wsb[i] = 4'hF; end
        do_write(4'd6, 32'h80, 8'd2, 2'b00, -1, 0);
        do_read(4'd8, 32'h80, 8'd1, 2'b01, 4'hF);
        chk("t3_fixed_last", gr_data(0), 32'd3);
        chk("t3_neighbour", gr_data(1), 32'hCAFE_F00D);

        // run off the end of the RAM
        wd[0] = 32'h1234_5678; wd[1] = 32'h9ABC_DEF0; wsb[0] = 4'hF; wsb[1] = 4'hF;
        do_write(4'd9, 32'(MEM_WORDS * 4 - 4), 8'd1, 2'b01, -1, 0);
        chk("t4_bresp", gb().resp, 2'b10);
        do_read(4'd10, 32'(MEM_WORDS * 4 - 4), 8'd1, 2'b01, 4'hF);
        chk("t4_b0_data", gr_data(0), 32'h1234_5678);
        chk("t4_b0_resp", gr_resp(0), 2'b00);
        chk("t4_b1_data", gr_data(1), 32'h0);
        chk("t4_b1_resp", gr_resp(1), 2'b10);

        // backpressure on B and R
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hB000_0000 + 32'(i); wsb[i] = 4'hF; end
        do_write(4'd11, 32'h100, 8'd3, 2'b01, -1, 5);
        chk("t5_bresp", gb().resp, 2'b00);
        do_read(4'd12, 32'h100, 8'd3, 2'b01, 4'b1001);
        for (int i = 0; i < 4; i++) chk("t5_rdata", gr_data(i), 32'hB000_0000 + 32'(i));

        // early wlast
        for (int i = 0; i < 4; i++) begin wd[i] = 32'h5A5A_0000 + 32'(i); wsb[i] = 4'hF; end
        do_write(4'd13, 32'h200, 8'd3, 2'b01, 1, 0);
        chk("t6_bresp", gb().resp, 2'b10);

        // WRAP from 0x18
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + 32'(i); wsb[i] = 4'hF; end
        do_write(4'd14, 32'h18, 8'd3, 2'b10, -1, 0);
        do_read(4'd15, 32'h10, 8'd3, 2'b01, 4'hF);
        if (WRAP_EN) begin
            chk("t7_bresp", gb().resp, 2'b00);
            chk("t7_w0x10", gr_data(0), 32'hA2);
            chk("t7_w0x14", gr_data(1), 32'hA3);
            chk("t7_w0x18", gr_data(2), 32'hA0);
            chk("t7_w0x1c", gr_data(3), 32'hA1);
        end else begin
            chk("t7_bresp", gb().resp, 2'b10);
            chk("t7_unchanged", gr_data(2), 32'h3333_3333);
        end
        do_read(4'd0, 32'h18, 8'd3, 2'b10, 4'hF);
        if (WRAP_EN) begin
            chk("t7_rwrap0", gr_data(0), 32'hA0);
            chk("t7_rwrap2", gr_data(2), 32'hA2);
            chk("t7_rresp", gr_resp(3), 2'b00);
        end else begin
            chk("t7_rresp0", gr_resp(0), 2'b10);
            chk("t7_rresp3", gr_resp(3), 2'b10);
            chk("t7_rdata3", gr_data(3), 32'h0);
            chk("t7_rlast2", gr_last(2), 1'b0);
            chk("t7_rlast3", gr_last(3), 1'b1);
        end

        chk("r_leftover", exp_r.size(), 0);
        chk("b_leftover", exp_b.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi4_slave_ram.md
Name: axi4_slave_ram

Overview:
AXI4 responder (slave) backed by a word-organised on-chip RAM, with independent read and write channel FSMs. It is the memory-side endpoint for the PicoRV32 AXI4 master bridge in the SoC-32bit subsystem. It supports single-beat and burst (FIXED/INCR) transfers with byte strobes and ID echo. Each direction has one outstanding transaction.

Parameters:
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 32, data width; fixed 32 in this block
ID_WIDTH, 4, AXI ID width
MEM_WORDS, 1024, RAM depth in 32-bit words; valid byte range 0 to MEM_WORDS*4-1
BASE_ADDR, 32'h0000_0000, byte address that maps to RAM word 0

Ports:
aclk  in  1  clock
areset  in  1  synchronous active-high reset
s_axi_awid/awaddr/awlen/awsize/awburst  in  ID/ADDR/8/3/2  write address
s_axi_awvalid  in  1 ; s_axi_awready  out  1
s_axi_wdata/wstrb/wlast  in  32/4/1 ; s_axi_wvalid  in  1 ; s_axi_wready  out  1
s_axi_bid  out  ID ; s_axi_bresp  out  2 ; s_axi_bvalid  out  1 ; s_axi_bready  in  1
s_axi_arid/araddr/arlen/arsize/arburst  in  ID/ADDR/8/3/2  read address
s_axi_arvalid  in  1 ; s_axi_arready  out  1
s_axi_rid  out  ID ; s_axi_rdata  out  32 ; s_axi_rresp  out  2 ; s_axi_rlast  out  1 ; s_axi_rvalid  out  1 ; s_axi_rready  in  1

Behaviour:
- Single clock aclk; reset is synchronous, active-high (areset). Reset drives awready=1, arready=1, wready=0, bvalid=0, rvalid=0, rlast=0, bresp=0, rresp=0, bid=0, rid=0, rdata=0, and both FSMs to IDLE. RAM contents are not reset. Reset asserted mid-burst abandons the burst; no B or R is issued for it.
- Write FSM states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: awready=1. An AW handshake latches id, addr, len, burst, and err (set when awsize!=3'b010 or awburst==2'b11). Next cycle: awready=0, wready=1, state W_DATA.
  - W_DATA: each W handshake writes the RAM word at the current address under wstrb, unless err is set or the address is out of range. Any out-of-range beat sets err. Beat counter beats = len+1 is authoritative. A wlast value that disagrees with the counter (early or missing on the final beat) sets err. After the final beat: wready=0, next cycle bvalid=1, state W_RESP.
  - W_RESP: bid = latched id; bresp = 2'b10 (SLVERR) if err, else 2'b00. Hold until bready. Then bvalid=0, awready=1, state W_IDLE.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: arready=1. AR handshake latches fields and err as for writes. Next cycle rvalid=1 with beat 0 data, arready=0.
  - R_DATA: rdata is registered and stable while rvalid && !rready. On a handshake, the next beat is presented in the following cycle with no bubble. rresp=SLVERR and rdata=0 for err or out-of-range beats. rlast=1 only on beat len. After the final handshake: rvalid=0, arready=1.
- Address update: FIXED keeps the address; INCR adds 4. The low 2 address bits are ignored for RAM indexing. Addresses are relative to BASE_ADDR. Addresses below BASE_ADDR are out of range.
- Same-cycle write and read to the same word: the read returns old data (read-before-write).
- Minimum latencies: AW to first wready = 1 cycle; last W to bvalid = 1 cycle; AR to rvalid = 1 cycle.

Optional Feature:
AXI_SLV_WRAP_EN
- Defined: awburst/arburst 2'b10 (WRAP) is accepted for len 1, 3, 7, or 15. The address wraps on a (len+1)*4-byte aligned boundary. WRAP with any other len, or with an unaligned start address, sets err.
- Undefined: WRAP is treated like reserved 2'b11. err is set, no RAM writes occur, and the correct beat count still completes with SLVERR.

Decomposition:
- Shared package axi4_pkg holds:
  - burst constants BURST_FIXED, BURST_INCR, BURST_WRAP
  - response constants RESP_OKAY, RESP_SLVERR
  - SIZE_4B=3'b010
  - FSM state typedefs
- One sub-module, axi4_burst_addr, is used twice (write and read). It is combinational: next address from (addr, len, burst), plus an in-range flag against BASE_ADDR/MEM_WORDS.

Test Plan:
- Reset, then INCR write awaddr=0x10, len=3, data 0x11111111..0x44444444, wstrb=4'hF. Expect bresp=00 and bid echoed. Read back arlen=3: same 4 words, rlast only on beat 3, all rresp=00.
- Single write 0xAABBCCDD, wstrb=4'b0101, over 0xFFFFFFFF at 0x40 → read 0x40 returns 0xFFBBFFDD.
- FIXED write len=2 to 0x80 with 1,2,3 → read 0x80 returns 3; read 0x84 unchanged.
- Out of range: awaddr=MEM_WORDS*4-4, INCR len=1 → first word written, bresp=10. Read same: beat 0 OKAY with data, beat 1 rresp=10, rdata=0.
- Backpressure: rready toggles 1-0-0-1 during a len=3 read, and bready is held low 5 cycles → rdata stable while stalled, no beat lost, bvalid held, awready=0 until B accepted.
- Wrong wlast (asserted on beat 1 of len=3), and WRAP len=3 from 0x18 → SLVERR/ordering. With AXI_SLV_WRAP_EN: addresses 0x18, 0x1C, 0x10, 0x14, OKAY. Without it: SLVERR with 4 beats and rlast on beat 3.
